// File: rtl/data_ram_arbiter_if.sv
// ----------------------------------------------------------------------------
// data_ram_arbiter_if: CPU, auxiliary and RAM-side bus of the data RAM arbiter.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface data_ram_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;
  logic              cpu_stall;

  logic              aux_req;
  logic              aux_we;
  logic [ADDR_W-1:0] aux_addr;
  logic [DATA_W-1:0] aux_wdata;
  logic              aux_gnt;
  logic [DATA_W-1:0] aux_rdata;
  logic              aux_rvalid;

  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_q;

  // Requesters and the RAM instance together form the master side.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_rvalid, cpu_stall,
    output aux_req, aux_we, aux_addr, aux_wdata,
    input  aux_gnt, aux_rdata, aux_rvalid,
    input  ram_address, ram_data, ram_wren,
    output ram_q
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_rvalid, cpu_stall,
    input  aux_req, aux_we, aux_addr, aux_wdata,
    output aux_gnt, aux_rdata, aux_rvalid,
    output ram_address, ram_data, ram_wren,
    input  ram_q
  );
endinterface

`default_nettype wire

// File: rtl/data_ram_arbiter.sv
// ----------------------------------------------------------------------------
// data_ram_arbiter: shares a single-port sync-read RAM between the CPU memory
// stage (default priority) and one auxiliary requester with bounded wait.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module data_ram_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int AUX_MAX_WAIT = 4
) (
  input  wire logic         clk,
  input  wire logic         reset,
  data_ram_arbiter_if.slave bus
);

  localparam logic [3:0] c_WAIT_MAX  = 4'(AUX_MAX_WAIT);
  localparam logic [3:0] c_WAIT_LAST = 4'(AUX_MAX_WAIT - 1);

  typedef enum logic [0:0] {
    CPU_PRI   = 1'b0,
    AUX_FORCE = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_wait_cnt;
  logic              r_cpu_rvalid;
  logic              r_aux_rvalid;
  logic              w_grant_cpu;
  logic              w_grant_aux;
  logic [ADDR_W-1:0] w_ram_address;
  logic [DATA_W-1:0] w_ram_data;
  logic              w_ram_wren;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= CPU_PRI;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_cpu = 1'b0;
    w_grant_aux = 1'b0;
    case (r_state)
      CPU_PRI: begin
        w_grant_cpu = bus.cpu_req;
        w_grant_aux = bus.aux_req & ~bus.cpu_req;
        if (bus.aux_req && !w_grant_aux && (r_wait_cnt == c_WAIT_LAST)) begin
          w_state_nxt = AUX_FORCE;
        end
      end
      AUX_FORCE: begin
        // Exactly one cycle of aux priority, whether or not aux still asks.
        w_grant_aux = bus.aux_req;
        w_grant_cpu = bus.cpu_req & ~bus.aux_req;
        w_state_nxt = CPU_PRI;
      end
      default: begin
        w_state_nxt = CPU_PRI;
      end
    endcase
  end

  always_comb begin
    w_ram_address = bus.cpu_addr;
    w_ram_data    = bus.cpu_wdata;
    w_ram_wren    = w_grant_cpu & bus.cpu_we;
    if (w_grant_aux) begin
      w_ram_address = bus.aux_addr;
      w_ram_data    = bus.aux_wdata;
      w_ram_wren    = bus.aux_we;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait_cnt   <= 4'd0;
      r_cpu_rvalid <= 1'b0;
      r_aux_rvalid <= 1'b0;
    end else begin
      r_cpu_rvalid <= w_grant_cpu & ~bus.cpu_we;
      r_aux_rvalid <= w_grant_aux & ~bus.aux_we;
      if (!bus.aux_req || w_grant_aux) begin
        r_wait_cnt <= 4'd0;
      end else if (r_wait_cnt != c_WAIT_MAX) begin
        r_wait_cnt <= r_wait_cnt + 4'd1;
      end
    end
  end

  assign bus.aux_gnt     = w_grant_aux;
  assign bus.cpu_stall   = bus.cpu_req & ~w_grant_cpu;
  assign bus.ram_address = w_ram_address;
  assign bus.ram_data    = w_ram_data;
  assign bus.ram_wren    = w_ram_wren;
  assign bus.cpu_rvalid  = r_cpu_rvalid;
  assign bus.aux_rvalid  = r_aux_rvalid;
  assign bus.cpu_rdata   = bus.ram_q;
  assign bus.aux_rdata   = bus.ram_q;

endmodule

`default_nettype wire
